mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Shares the single-port unified instruction/data memory between the stack-CPU
//  datapath (port C) and an external loader/debug port (port E). Grants one access
//  per cycle. Returns read data one cycle after grant. Raises cpu_stall so the
//  multicycle controller freezes its state while the CPU port waits.
// PARAMETERS
//  ADDR_W     5  memory address width
//  DATA_W     8  memory data width
//  MAX_BURST  4  max consecutive locked E grants while C is requesting (>=1)
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       synchronous, active-high reset
//  c_req      in   1       CPU access request; held until c_gnt
//  c_we       in   1       CPU write enable (1=write, 0=read)
//  c_addr     in   ADDR_W  CPU address
//  c_wdata    in   DATA_W  CPU write data
//  c_gnt      out  1       CPU access issued to memory this cycle
//  c_rvalid   out  1       c_rdata valid (cycle after a CPU read grant)
//  c_rdata    out  DATA_W  CPU read data
//  cpu_stall  out  1       c_req & ~c_gnt
//  e_req      in   1       external request; held until e_gnt
//  e_we       in   1       external write enable
//  e_lock     in   1       E requests burst priority
//  e_addr     in   ADDR_W  external address
//  e_wdata    in   DATA_W  external write data
//  e_gnt      out  1       external access issued this cycle
//  e_rvalid   out  1       e_rdata valid
//  e_rdata    out  DATA_W  external read data
//  mem_en     out  1       memory access strobe
//  mem_we     out  1       memory write strobe
//  mem_addr   out  ADDR_W  memory address
//  mem_wdata  out  DATA_W  memory write data
//  mem_rdata  in   DATA_W  memory read data, valid 1 cycle after mem_en & ~mem_we
// BEHAVIOUR
//  - Grant decision combinational from req inputs + registered state; at most one
//    of c_gnt/e_gnt per cycle; mem_en = c_gnt|e_gnt; mem_we/addr/wdata muxed from
//    winner; mem_addr/mem_wdata = 0 and mem_we = 0 when mem_en = 0.
//  - State: last (C/E, last winner), bcnt (burst count, 0..MAX_BURST), rsel (1-cycle
//    read-return owner pipe: NONE/C/E).
//  - Only one requester: it wins every cycle it requests (back-to-back allowed).
//  - Both requesting, e_lock=0 or last=C: round-robin, winner = not(last).
//  - Both requesting, e_lock=1 and last=E: E wins while bcnt < MAX_BURST; when
//    bcnt = MAX_BURST, C wins (forced yield) and bcnt clears.
//  - bcnt increments on each E grant while c_req=1 and e_lock=1; clears on any C
//    grant, on e_lock=0, or on a cycle with no E grant.
//  - Read return: on grant with we=0, rsel <= winner; next cycle that port's rvalid=1
//    and its rdata = mem_rdata. rdata of the other port holds its last value.
//    Writes produce no rvalid. Write latency: committed at grant edge.
//  - Requester may change addr/we/data the cycle after gnt; a new req may overlap its
//    own rvalid cycle.
//  - Reset: last=E (C wins first tie), bcnt=0, rsel=NONE; outputs c_gnt, e_gnt,
//    c_rvalid, e_rvalid, mem_en, mem_we = 0; c_rdata, e_rdata, mem_addr,
//    mem_wdata = 0; cpu_stall = 0 during reset cycle. Reset asserted the cycle after a
//    read grant drops that rvalid.
//  - req with X-free inputs only; no request queuing inside the block.
// TESTING
//  1 C-only reads addr 3,4,5 back-to-back -> c_gnt 3 cycles, c_rvalid cycles 2-4
//    with mem[3],mem[4],mem[5]; cpu_stall stays 0.
//  2 C and E both req, e_lock=0, after reset -> grants C,E,C,E alternate; cpu_stall=1
//    exactly on E-grant cycles.
//  3 E write 0xA5 to addr 7, then C read addr 7 next cycle -> c_rdata=0xA5 with
//    c_rvalid 1 cycle after c_gnt.
//  4 Both req continuously, e_lock=1, MAX_BURST=4, last=E -> E,E,E,E,C,E,E,E,E,C...
//    cpu_stall high 4 of every 5 cycles.
//  5 E read granted, rst=1 next cycle -> e_rvalid=0, all outputs 0; after rst first
//    tie goes to C.
//  6 No requests -> mem_en=0, mem_we=0, both gnt=0 for all cycles; bcnt stays 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory between the CPU port (C) and an external loader/debug port (E).
// Latency: grant is combinational in the request cycle; read data returns one cycle after the grant.
// Backpressure: a requester holds req until its gnt; a C requester left waiting sees cpu_stall.
//
// Ports:
//   clk, rst                            clock (rising edge), synchronous active-high reset
//   c_req/c_we/c_addr/c_wdata           CPU access request, held until c_gnt
//   c_gnt, c_rvalid, c_rdata, cpu_stall CPU grant, read return and stall indication
//   e_req/e_we/e_lock/e_addr/e_wdata    external access request, e_lock asks for burst priority
//   e_gnt, e_rvalid, e_rdata            external grant and read return
//   mem_en/mem_we/mem_addr/mem_wdata    memory strobes, driven by the winning port
//   mem_rdata                           memory read data, valid one cycle after a read strobe
module mem_arbiter #(
   parameter int ADDR_W    = 5,
   parameter int DATA_W    = 8,
   parameter int MAX_BURST = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              c_req,
   input  logic              c_we,
   input  logic [ADDR_W-1:0] c_addr,
   input  logic [DATA_W-1:0] c_wdata,
   output logic              c_gnt,
   output logic              c_rvalid,
   output logic [DATA_W-1:0] c_rdata,
   output logic              cpu_stall,
   input  logic              e_req,
   input  logic              e_we,
   input  logic              e_lock,
   input  logic [ADDR_W-1:0] e_addr,
   input  logic [DATA_W-1:0] e_wdata,
   output logic              e_gnt,
   output logic              e_rvalid,
   output logic [DATA_W-1:0] e_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int BW = $clog2(MAX_BURST + 1);
   localparam logic [BW-1:0] BCNT_MAX = BW'(MAX_BURST);

   // Read-return owner for the cycle after a read grant.
   localparam logic [1:0] RSEL_NONE = 2'd0;
   localparam logic [1:0] RSEL_C    = 2'd1;
   localparam logic [1:0] RSEL_E    = 2'd2;

   logic              last_e;   // 1 when E won the most recent grant
   logic [BW-1:0]     bcnt;     // consecutive locked E grants taken while C waited
   logic [1:0]        rsel;
   logic [DATA_W-1:0] c_hold;   // last data returned to each port, held between reads
   logic [DATA_W-1:0] e_hold;

   logic c_win;
   logic e_win;
   logic burst_spent;

   assign burst_spent = (bcnt >= BCNT_MAX);

   // Grant decision. Everything is forced idle while reset is asserted so the
   // memory never sees a strobe in the reset cycle.
   always_comb begin
      c_win = 1'b0;
      e_win = 1'b0;
      if (!rst) begin
         if (c_req && e_req) begin
            if (e_lock && last_e) begin
               // E holds the memory for a locked burst, but C is guaranteed
               // a slot once the burst budget is used up.
               if (burst_spent) c_win = 1'b1;
               else             e_win = 1'b1;
            end else if (last_e) begin
               c_win = 1'b1;
            end else begin
               e_win = 1'b1;
            end
         end else if (c_req) begin
            c_win = 1'b1;
         end else if (e_req) begin
            e_win = 1'b1;
         end
      end
   end

   assign c_gnt     = c_win;
   assign e_gnt     = e_win;
   assign cpu_stall = c_req & ~c_win & ~rst;

   // Memory strobes come from the winner and are zeroed when nobody wins, so
   // the memory bus is quiet rather than echoing a stale request.
   assign mem_en    = c_win | e_win;
   assign mem_we    = c_win ? c_we    : (e_win ? e_we    : 1'b0);
   assign mem_addr  = c_win ? c_addr  : (e_win ? e_addr  : '0);
   assign mem_wdata = c_win ? c_wdata : (e_win ? e_wdata : '0);

   // Read return: the owning port sees mem_rdata directly in its rvalid cycle
   // and the captured copy afterwards. Reset drops an in-flight return.
   assign c_rvalid = ~rst & (rsel == RSEL_C);
   assign e_rvalid = ~rst & (rsel == RSEL_E);
   assign c_rdata  = rst ? '0 : (c_rvalid ? mem_rdata : c_hold);
   assign e_rdata  = rst ? '0 : (e_rvalid ? mem_rdata : e_hold);

   always_ff @(posedge clk) begin
      if (rst) begin
         last_e <= 1'b1;          // first contested cycle after reset goes to C
         bcnt   <= '0;
         rsel   <= RSEL_NONE;
         c_hold <= '0;
         e_hold <= '0;
      end else begin
         if (c_win)      last_e <= 1'b0;
         else if (e_win) last_e <= 1'b1;

         // Burst counting only matters while C is actually waiting; a locked
         // E grant with C idle neither advances nor resets the budget.
         if (e_win && e_lock) begin
            if (c_req && !burst_spent) bcnt <= bcnt + BW'(1);
         end else begin
            bcnt <= '0;
         end

         if (c_win && !c_we)      rsel <= RSEL_C;
         else if (e_win && !e_we) rsel <= RSEL_E;
         else                     rsel <= RSEL_NONE;

         if (c_rvalid) c_hold <= mem_rdata;
         if (e_rvalid) e_hold <= mem_rdata;
      end
   end

endmodule
